// File: rtl/centroid_pkg.sv
// Shared definitions for the centroid divider scheduler: operand and
// coordinate widths, default image geometry and the sequencer state encoding.
package centroid_pkg;

    localparam int M00_W           = 20;   // pixel-count moment width
    localparam int M_W             = 28;   // first-order moment / quotient width
    localparam int COORD_W         = 12;   // centroid coordinate width
    localparam int IMG_W_DEF       = 720;  // default image width in pixels
    localparam int IMG_H_DEF       = 576;  // default image height in lines
    localparam int DIV_TIMEOUT_DEF = 64;   // default divider wait budget in cycles

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_X,
        ST_WAIT_X,
        ST_START_Y,
        ST_WAIT_Y,
        ST_DONE
    } state_t;

    // Clamp a quotient to lim. The compare runs on the full quotient width so
    // a large quotient can never alias to a small coordinate after narrowing.
    function automatic logic [COORD_W-1:0] sat_coord(
        input logic [M_W-1:0] q,
        input logic [M_W-1:0] lim
    );
        return (q > lim) ? lim[COORD_W-1:0] : q[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/centroid_div_sched.sv
// Centroid divider scheduler: on end-of-frame it snapshots the frame moments,
// issues two divisions (m01/m00 for x, m10/m00 for y) to an external shared
// divider, saturates the quotients to the image bounds and publishes x/y.
module centroid_div_sched
    import centroid_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               eof,
    input  logic [M00_W-1:0]   m00,
    input  logic [M_W-1:0]     m01,
    input  logic [M_W-1:0]     m10,
    output logic               div_start,
    output logic [M_W-1:0]     div_dividend,
    output logic [M00_W-1:0]   div_divisor,
    input  logic [M_W-1:0]     div_quotient,
    input  logic               div_qv,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               xy_valid,
    output logic               empty,
    output logic               busy,
    output logic               overrun,
    output logic               timeout
);

    localparam int               CNT_W    = $clog2(DIV_TIMEOUT + 1);
    // Last wait count that still accepts a quotient; counting starts at 0 in
    // the START cycle, so timeout appears DIV_TIMEOUT cycles after div_start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [M_W-1:0]   X_MAX    = M_W'(IMG_W - 1);
    localparam logic [M_W-1:0]   Y_MAX    = M_W'(IMG_H - 1);

    state_t             state;
    logic [M00_W-1:0]   snap_m00;
    logic [M_W-1:0]     snap_m01;
    logic [M_W-1:0]     snap_m10;
    logic [COORD_W-1:0] pend_x;
    logic [CNT_W-1:0]   cnt;

    // Sequencer: state, snapshot, divider handshake, timeout counter and all
    // registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here, snapshot and counter included, is cleared
        // by the async reset so an aborted division leaves no residue behind.
        if (!rst_n) begin
            state        <= ST_IDLE;
            snap_m00     <= '0;
            snap_m01     <= '0;
            snap_m10     <= '0;
            pend_x       <= '0;
            cnt          <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            x            <= '0;
            y            <= '0;
            xy_valid     <= 1'b0;
            empty        <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle and are raised only in
            // the branch that produces them, giving exact one-cycle pulses.
            div_start <= 1'b0;
            xy_valid  <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= eof && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (eof) begin
                        snap_m00 <= m00;
                        snap_m01 <= m01;
                        snap_m10 <= m10;
                        busy     <= 1'b1;
                        if (m00 == '0) begin
                            empty    <= 1'b1;
                            xy_valid <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            div_start    <= 1'b1;
                            div_dividend <= m01;
                            div_divisor  <= m00;
                            cnt          <= '0;
                            state        <= ST_START_X;
                        end
                    end
                end
                ST_START_X: begin
                    div_dividend <= snap_m01;
                    div_divisor  <= snap_m00;
                    cnt          <= CNT_W'(1);
                    state        <= ST_WAIT_X;
                end
                ST_WAIT_X: begin
                    if (div_qv) begin
                        pend_x       <= sat_coord(div_quotient, X_MAX);
                        div_start    <= 1'b1;
                        div_dividend <= snap_m10;
                        cnt          <= '0;
                        state        <= ST_START_Y;
                    end else if (cnt == CNT_LAST) begin
                        timeout      <= 1'b1;
                        busy         <= 1'b0;
                        div_dividend <= '0;
                        div_divisor  <= '0;
                        cnt          <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_START_Y: begin
                    cnt   <= CNT_W'(1);
                    state <= ST_WAIT_Y;
                end
                ST_WAIT_Y: begin
                    if (div_qv) begin
                        x            <= pend_x;
                        y            <= sat_coord(div_quotient, Y_MAX);
                        empty        <= 1'b0;
                        xy_valid     <= 1'b1;
                        div_dividend <= '0;
                        div_divisor  <= '0;
                        cnt          <= '0;
                        state        <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        timeout      <= 1'b1;
                        busy         <= 1'b0;
                        div_dividend <= '0;
                        div_divisor  <= '0;
                        cnt          <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_div_sched.sv
// Testbench for centroid_div_sched: directed frames against an external
// divider model, a per-cycle reference model of the frame protocol, and
// hand-computed literal expectations for each scenario.
module tb_centroid_div_sched;
    import centroid_pkg::*;

    localparam int TMO = DIV_TIMEOUT_DEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eof = 1'b0;
    logic [19:0] m00 = '0;
    logic [27:0] m01 = '0;
    logic [27:0] m10 = '0;
    logic        div_start;
    logic [27:0] div_dividend;
    logic [19:0] div_divisor;
    logic [27:0] div_quotient = '0;
    logic        div_qv = 1'b0;
    logic [11:0] x;
    logic [11:0] y;
    logic        xy_valid;
    logic        empty;
    logic        busy;
    logic        overrun;
    logic        timeout;

    centroid_div_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .eof          (eof),
        .m00          (m00),
        .m01          (m01),
        .m10          (m10),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_qv       (div_qv),
        .x            (x),
        .y            (y),
        .xy_valid     (xy_valid),
        .empty        (empty),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- divider model (fixed latency, can be muted) ----------
    bit          reply = 1'b1;
    int          lat = 30;
    int          dv_pend = 0;
    logic [27:0] dv_q = '0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            div_qv = 1'b0;
            if (dv_pend > 0) begin
                dv_pend--;
                if (dv_pend == 0) begin
                    div_qv       = 1'b1;
                    div_quotient = dv_q;
                end
            end
            if (div_start && reply) begin
                dv_pend = lat;
                dv_q    = div_dividend / 28'(div_divisor);
            end
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    function automatic logic [11:0] sat(input logic [27:0] q, input int lim);
        int v;
        v = (longint'(q) > longint'(lim)) ? lim : int'(q);
        return 12'(v);
    endfunction

    // expectations for the current cycle
    bit          e_start = 0, e_valid = 0, e_busy = 0, e_over = 0, e_tmo = 0;
    logic [27:0] e_dd = '0;
    logic [19:0] e_dv = '0;
    logic [11:0] ex = '0, ey = '0, px = '0;
    bit          eempty = 0;
    // frame progress
    bit          m_wait = 0;
    int          m_age = 0;
    int          m_qn = 0;
    logic [27:0] s10 = '0;
    // observation log used by the directed checks
    int start_count = 0, valid_count = 0, over_count = 0, tmo_count = 0, qv_count = 0;
    int last_valid_cyc = 0, last_tmo_cyc = 0, last_qv_cyc = 0;
    int start_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (div_qv) begin
                qv_count++;
                last_qv_cyc = cyc;
            end
            if (!rst_n) begin
                check("rst_xy", {8'd0, x, y}, 32'd0);
                check("rst_flags", {26'd0, empty, xy_valid, busy, overrun, timeout, div_start}, 32'd0);
                check("rst_dividend", {4'd0, div_dividend}, 32'd0);
                check("rst_divisor", {12'd0, div_divisor}, 32'd0);
                e_start = 0; e_valid = 0; e_busy = 0; e_over = 0; e_tmo = 0;
                e_dd = '0; e_dv = '0; ex = '0; ey = '0; px = '0; eempty = 0;
                m_wait = 0; m_age = 0; m_qn = 0;
            end else begin
                check("x", {20'd0, x}, {20'd0, ex});
                check("y", {20'd0, y}, {20'd0, ey});
                check("empty", {31'd0, empty}, {31'd0, eempty});
                check("xy_valid", {31'd0, xy_valid}, {31'd0, e_valid});
                check("busy", {31'd0, busy}, {31'd0, e_busy});
                check("overrun", {31'd0, overrun}, {31'd0, e_over});
                check("timeout", {31'd0, timeout}, {31'd0, e_tmo});
                check("div_start", {31'd0, div_start}, {31'd0, e_start});
                check("div_dividend", {4'd0, div_dividend}, {4'd0, e_dd});
                check("div_divisor", {12'd0, div_divisor}, {12'd0, e_dv});
                if (div_start) begin start_count++; start_log.push_back(cyc); end
                if (xy_valid) begin valid_count++; last_valid_cyc = cyc; end
                if (overrun) over_count++;
                if (timeout) begin tmo_count++; last_tmo_cyc = cyc; end

                // derive next-cycle expectations from this cycle's events
                e_over  = eof && e_busy;
                e_start = 0;
                e_tmo   = 0;
                if (e_valid) begin
                    e_valid = 0;
                    e_busy  = 0;
                end else if (m_wait) begin
                    if (div_qv && m_age >= 1) begin
                        if (m_qn == 0) begin
                            px      = sat(div_quotient, IMG_W_DEF - 1);
                            m_qn    = 1;
                            e_start = 1;
                            e_dd    = s10;
                            m_age   = 0;
                        end else begin
                            ex      = px;
                            ey      = sat(div_quotient, IMG_H_DEF - 1);
                            eempty  = 0;
                            e_valid = 1;
                            e_dd    = '0;
                            e_dv    = '0;
                            m_wait  = 0;
                        end
                    end else if (m_age == TMO - 1) begin
                        e_tmo  = 1;
                        e_busy = 0;
                        e_dd   = '0;
                        e_dv   = '0;
                        m_wait = 0;
                    end else begin
                        m_age++;
                    end
                end else if (!e_busy && eof) begin
                    e_busy = 1;
                    s10    = m10;
                    if (m00 == 0) begin
                        eempty  = 1;
                        e_valid = 1;
                    end else begin
                        e_start = 1;
                        e_dd    = m01;
                        e_dv    = m00;
                        m_wait  = 1;
                        m_qn    = 0;
                        m_age   = 0;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int eof_cyc = 0;

    task automatic send_eof(input logic [19:0] a, input logic [27:0] b, input logic [27:0] c);
        @(posedge clk);
        #1;
        m00 = a; m01 = b; m10 = c;
        eof = 1'b1;
        eof_cyc = cyc;
        @(posedge clk);
        #1;
        eof = 1'b0;
    endtask

    task automatic wait_valid(input int base, input int bound);
        int n = 0;
        while (valid_count == base && n < bound) begin
            @(posedge clk);
            n++;
        end
        check("wait_xy_valid", {31'd0, valid_count > base}, 32'd1);
    endtask

    // saturation table: m00, m01, m10, expected x, expected y
    int sat_tab[5][5] = '{
        '{1, 5000, 9000, 719, 575},
        '{1, 719,  575,  719, 575},
        '{2, 1440, 1152, 719, 575},
        '{1, 4101, 4099, 719, 575},
        '{3, 30,   21,   10,  7}
    };

    int v0, s0, o0, t0, q0, e1;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_xy", {8'd0, x, y}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // nominal frame, divider latency 30
        lat = 30; v0 = valid_count; s0 = start_count;
        send_eof(20'd504, 28'd13860, 28'd12526);
        wait_valid(v0, 200);
        check("t1_x", {20'd0, x}, 32'd27);
        check("t1_y", {20'd0, y}, 32'd24);
        check("t1_empty", {31'd0, empty}, 32'd0);
        check("t1_starts", start_count - s0, 32'd2);
        check("t1_start_lat", start_log[s0] - eof_cyc, 32'd1);
        check("t1_valid_lat", last_valid_cyc - last_qv_cyc, 32'd1);

        // empty frame
        v0 = valid_count; s0 = start_count;
        send_eof(20'd0, 28'd123, 28'd456);
        wait_valid(v0, 20);
        check("t2_valid_lat", last_valid_cyc - eof_cyc, 32'd1);
        check("t2_empty", {31'd0, empty}, 32'd1);
        check("t2_x_held", {20'd0, x}, 32'd27);
        check("t2_y_held", {20'd0, y}, 32'd24);
        check("t2_no_start", start_count - s0, 32'd0);

        // saturation boundaries, short divider latency
        lat = 3;
        for (int i = 0; i < 5; i++) begin
            v0 = valid_count;
            send_eof(20'(sat_tab[i][0]), 28'(sat_tab[i][1]), 28'(sat_tab[i][2]));
            wait_valid(v0, 50);
            check($sformatf("t3_x_%0d", i), {20'd0, x}, sat_tab[i][3]);
            check($sformatf("t3_y_%0d", i), {20'd0, y}, sat_tab[i][4]);
            check($sformatf("t3_empty_%0d", i), {31'd0, empty}, 32'd0);
        end

        // second eof while busy is dropped
        lat = 30; v0 = valid_count; o0 = over_count;
        send_eof(20'd100, 28'd5000, 28'd3000);
        e1 = eof_cyc;
        repeat (3) @(posedge clk);
        send_eof(20'd10, 28'd1000, 28'd2000);
        check("t4_eof_gap", eof_cyc - e1, 32'd5);
        wait_valid(v0, 200);
        repeat (5) @(posedge clk);
        check("t4_overrun", over_count - o0, 32'd1);
        check("t4_one_result", valid_count - v0, 32'd1);
        check("t4_x", {20'd0, x}, 32'd50);
        check("t4_y", {20'd0, y}, 32'd30);

        // divider never answers
        reply = 1'b0; v0 = valid_count; t0 = tmo_count; s0 = start_count;
        send_eof(20'd100, 28'd6000, 28'd4000);
        for (int n = 0; n < 200 && tmo_count == t0; n++) @(posedge clk);
        check("t5_timeout_seen", tmo_count - t0, 32'd1);
        check("t5_timeout_lat", last_tmo_cyc - start_log[s0], 32'd64);
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_x_held", {20'd0, x}, 32'd50);
        check("t5_y_held", {20'd0, y}, 32'd30);
        check("t5_no_valid", valid_count - v0, 32'd0);
        reply = 1'b1; v0 = valid_count;
        send_eof(20'd200, 28'd20000, 28'd10000);
        wait_valid(v0, 200);
        check("t5_next_x", {20'd0, x}, 32'd100);
        check("t5_next_y", {20'd0, y}, 32'd50);

        // reset during WAIT_Y; the in-flight quotient arrives afterwards
        lat = 30; s0 = start_count;
        send_eof(20'd504, 28'd13860, 28'd12526);
        for (int n = 0; n < 200 && start_count < s0 + 2; n++) @(posedge clk);
        check("t6_in_wait_y", start_count - s0, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_rst_xy", {8'd0, x, y}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        v0 = valid_count; q0 = qv_count;
        repeat (40) @(posedge clk);
        check("t6_stale_qv_seen", qv_count - q0, 32'd1);
        check("t6_no_valid", valid_count - v0, 32'd0);
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
